// File: rtl/instr_encoder.sv
// RV32I R-type / I-type ALU instruction encoder with an output FIFO and byte-address stream.
// Optional: define ENCODER_ERR_NOP_EN to push a NOP in place of each invalid request.
module instr_encoder #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_alu_control,
  input  logic        req_imm_en,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [11:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [6:0]  OP_R  = 7'b0110011;
  localparam logic [6:0]  OP_I  = 7'b0010011;
  localparam logic [6:0]  F7_ALT = 7'b0100000;

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_shift;
  logic        code_ok;
  logic        req_ok;
  logic [31:0] enc_word;
  logic [31:0] push_word;
  logic        accept;
  logic        push;
  logic        pop;

  logic [CNT_W-1:0] count_q, count_d, after_pop;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_pulse_q, err_pulse_d;
  logic [7:0]       err_count_q, err_count_d;

  // Field decode and word assembly for the incoming request
  always_comb begin
    funct3   = 3'b000;
    funct7   = 7'b0000000;
    is_shift = 1'b0;
    code_ok  = 1'b1;
    case (req_alu_control)
      6'd1:  funct3 = 3'b000;
      6'd2:  begin funct3 = 3'b000; funct7 = F7_ALT; end
      6'd3:  begin funct3 = 3'b001; is_shift = 1'b1; end
      6'd4:  funct3 = 3'b010;
      6'd5:  funct3 = 3'b011;
      6'd6:  funct3 = 3'b100;
      6'd7:  begin funct3 = 3'b101; is_shift = 1'b1; end
      6'd8:  begin funct3 = 3'b101; funct7 = F7_ALT; is_shift = 1'b1; end
      6'd9:  funct3 = 3'b110;
      6'd10: funct3 = 3'b111;
      default: code_ok = 1'b0;
    endcase
    req_ok = code_ok && !((req_alu_control == 6'd2) && req_imm_en);
    if (req_imm_en) begin
      // Shift immediates carry funct7 in the upper seven bits
      enc_word = {(is_shift ? {funct7, req_imm[4:0]} : req_imm), req_rs1, funct3, req_rd, OP_I};
    end else begin
      enc_word = {funct7, req_rs2, req_rs1, funct3, req_rd, OP_R};
    end
  end

  assign accept = req_valid && ready_q;
  assign pop    = valid_q && out_ready;

`ifdef ENCODER_ERR_NOP_EN
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  assign push      = accept;
  assign push_word = req_ok ? enc_word : NOP_WORD;
`else
  assign push      = accept && req_ok;
  assign push_word = enc_word;
`endif

  // FIFO bookkeeping, registered head/status and address/error tracking
  always_comb begin
    mem_d       = mem_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    after_pop   = count_q - CNT_W'(pop);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    instr_d     = instr_q;
    addr_d      = addr_q;
    err_pulse_d = accept && !req_ok;
    err_count_d = err_count_q;

    if (push) mem_d[wr_ptr_q] = push_word;

    // When the FIFO drains to zero before this push, the new word becomes the head directly
    if (count_d != '0) begin
      instr_d = (after_pop == '0) ? push_word : mem_q[rd_ptr_d];
    end

    if (pop) addr_d = (addr_q == ADDR_LIMIT) ? BASE_ADDR : addr_q + 32'd4;

    if (err_pulse_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;

    ready_d = (count_d != CNT_W'(DEPTH));
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      addr_q      <= BASE_ADDR;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      mem_q       <= mem_d;
    end
  end

  assign req_ready = ready_q;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule
